// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: owns the PWM period counter and the duty register.
// Duty changes come from ramp commands (valid/ready) or from single-step
// inc/dec pulses. Every change lands on a period boundary, so no PWM period
// is ever cut short or glitched.
module pwm_duty_sequencer #(
    parameter int DUTY_W    = 4,
    parameter int PERIOD    = 10,
    parameter int DUTY_MAX  = 10,
    parameter int DUTY_INIT = 5,
    parameter int RATE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [RATE_W-1:0] cmd_rate,
    input  logic              abort,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm_out,
    output logic              period_start,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DUTY_INIT);
    localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);
    localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

    typedef enum logic { S_IDLE, S_RAMP } state_t;
    typedef enum logic [1:0] { P_NONE, P_INC, P_DEC } pend_t;

    logic [CNT_W-1:0]  cnt_q;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] tgt_q;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] step_q;
    state_t            state_q;
    pend_t             pend_q;
    logic              done_q;

    logic              boundary;
    logic              step_due;
    logic [DUTY_W-1:0] cmd_tgt_clamped;
    logic [DUTY_W-1:0] ramp_next;
    logic [DUTY_W-1:0] manual_next;
    pend_t             pend_d;

    assign boundary        = (cnt_q == CNT_LAST);
    assign step_due        = boundary && (step_q == '0);
    assign cmd_tgt_clamped = (cmd_target > DUTY_TOP) ? DUTY_TOP : cmd_target;
    // A ramp never starts with tgt == duty, so one step toward tgt is always legal.
    assign ramp_next       = (tgt_q > duty_q) ? (duty_q + DUTY_ONE) : (duty_q - DUTY_ONE);

    // Pending manual step: a lone pulse overrides any older request, inc+dec together is dropped.
    always_comb begin
        // NOTE: default assignment first so no path leaves pend_d unassigned (no latch).
        pend_d = pend_q;
        if (inc_pulse && !dec_pulse) begin
            pend_d = P_INC;
        end else if (dec_pulse && !inc_pulse) begin
            pend_d = P_DEC;
        end
    end

    // Duty after applying the pending manual step, saturating at 0 and DUTY_MAX.
    always_comb begin
        manual_next = duty_q;
        case (pend_d)
            P_INC:   if (duty_q < DUTY_TOP) manual_next = duty_q + DUTY_ONE;
            P_DEC:   if (duty_q != '0)      manual_next = duty_q - DUTY_ONE;
            default: manual_next = duty_q;
        endcase
    end

    // Free-running period counter, 0..PERIOD-1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else if (boundary) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // Sequencer FSM: command accept, ramp stepping, manual steps, abort and done pulse.
    always_ff @(posedge clk) begin
        // NOTE: every register has a defined reset value; there is no memory array here to leave unreset.
        if (rst) begin
            state_q <= S_IDLE;
            duty_q  <= DUTY_RST;
            tgt_q   <= DUTY_RST;
            rate_q  <= '0;
            step_q  <= '0;
            pend_q  <= P_NONE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // A new command discards any manual step in flight.
                        pend_q <= P_NONE;
                        tgt_q  <= cmd_tgt_clamped;
                        rate_q <= cmd_rate;
                        if (cmd_tgt_clamped == duty_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_RAMP;
                            step_q  <= cmd_rate;
                        end
                    end else if (boundary) begin
                        duty_q <= manual_next;
                        pend_q <= P_NONE;
                    end else begin
                        pend_q <= pend_d;
                    end
                end
                S_RAMP: begin
                    if (step_due && (ramp_next == tgt_q)) begin
                        // Final step completes even when abort arrives on the same edge.
                        duty_q  <= ramp_next;
                        step_q  <= rate_q;
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else if (abort) begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                    end else if (step_due) begin
                        duty_q <= ramp_next;
                        step_q <= rate_q;
                    end else if (boundary) begin
                        step_q <= step_q - RATE_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign duty         = duty_q;
    assign done         = done_q;
    assign busy         = (state_q == S_RAMP);
    assign cmd_ready    = (state_q == S_IDLE);
    assign period_start = (cnt_q == '0);
    assign pwm_out      = ({{(32 - CNT_W){1'b0}}, cnt_q} < {{(32 - DUTY_W){1'b0}}, duty_q});

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Testbench for pwm_duty_sequencer: directed scenarios followed by random
// traffic, all checked against a reference model that derives duty from the
// number of period boundaries seen since a command was accepted.
module tb_pwm_duty_sequencer;

    localparam int DUTY_W    = 4;
    localparam int PERIOD    = 10;
    localparam int DUTY_MAX  = 10;
    localparam int DUTY_INIT = 5;
    localparam int RATE_W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [DUTY_W-1:0] cmd_target = '0;
    logic [RATE_W-1:0] cmd_rate = '0;
    logic              abort = 1'b0;
    logic              inc_pulse = 1'b0;
    logic              dec_pulse = 1'b0;
    logic              cmd_ready;
    logic [DUTY_W-1:0] duty;
    logic              pwm_out;
    logic              period_start;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    pwm_duty_sequencer #(
        .DUTY_W(DUTY_W), .PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX),
        .DUTY_INIT(DUTY_INIT), .RATE_W(RATE_W)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_rate(cmd_rate), .abort(abort),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .duty(duty),
        .pwm_out(pwm_out), .period_start(period_start), .busy(busy), .done(done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_cnt  = 0;
    int m_duty = DUTY_INIT;
    int m_pend = 0;        // +1, -1 or 0
    bit m_ramp = 1'b0;
    bit m_done = 1'b0;
    int r_d0, r_tgt, r_rate, r_nb;
    int dut_done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and update the model from the inputs sampled at that edge.
    task automatic tick();
        bit bnd, step_edge, fin;
        int dir, cand;
        @(posedge clk);
        bnd    = (m_cnt == PERIOD - 1);
        m_done = 1'b0;
        if (rst) begin
            m_cnt  = 0;
            m_duty = DUTY_INIT;
            m_pend = 0;
            m_ramp = 1'b0;
        end else begin
            m_cnt = (m_cnt + 1) % PERIOD;
            if (!m_ramp) begin
                if (cmd_valid) begin
                    m_pend = 0;
                    r_tgt  = (int'(cmd_target) > DUTY_MAX) ? DUTY_MAX : int'(cmd_target);
                    r_rate = int'(cmd_rate);
                    if (r_tgt == m_duty) begin
                        m_done = 1'b1;
                    end else begin
                        m_ramp = 1'b1;
                        r_d0   = m_duty;
                        r_nb   = 0;
                    end
                end else begin
                    if (inc_pulse && !dec_pulse) m_pend = 1;
                    else if (dec_pulse && !inc_pulse) m_pend = -1;
                    if (bnd) begin
                        m_duty = m_duty + m_pend;
                        if (m_duty > DUTY_MAX) m_duty = DUTY_MAX;
                        if (m_duty < 0) m_duty = 0;
                        m_pend = 0;
                    end
                end
            end else begin
                if (bnd) r_nb++;
                dir       = (r_tgt > r_d0) ? 1 : -1;
                step_edge = bnd && (r_nb % (r_rate + 1) == 0);
                cand      = r_d0 + dir * (r_nb / (r_rate + 1));
                fin       = step_edge && (cand == r_tgt);
                if (fin) begin
                    m_duty = cand;
                    m_ramp = 1'b0;
                    m_done = 1'b1;
                end else if (abort) begin
                    m_ramp = 1'b0;
                end else begin
                    m_duty = cand;
                end
            end
        end
        #1;
    endtask

    // One clock plus a full comparison of every output against the model.
    task automatic cycle();
        tick();
        if (done === 1'b1) dut_done_cnt++;
        check("duty", duty, m_duty);
        check("pwm_out", pwm_out, m_cnt < m_duty);
        check("period_start", period_start, m_cnt == 0);
        check("busy", busy, m_ramp);
        check("cmd_ready", cmd_ready, !m_ramp);
        check("done", done, m_done);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < PERIOD && m_cnt != c; i++) cycle();
    endtask

    task automatic send_cmd(input int tgt, input int rate);
        cmd_valid  = 1'b1;
        cmd_target = DUTY_W'(tgt);
        cmd_rate   = RATE_W'(rate);
        cycle();
        cmd_valid  = 1'b0;
    endtask

    // Wait for the DUT to leave RAMP; returns cycles spent waiting.
    task automatic wait_ramp_end(input string tag, input int bound, output int lat);
        lat = 0;
        while (busy === 1'b1 && lat < bound) begin
            cycle();
            lat++;
        end
        check({tag, ".ramp_timeout"}, busy, 0);
    endtask

    task automatic wait_duty(input string tag, input int v, input int bound);
        int n = 0;
        while (duty !== DUTY_W'(v) && n < bound) begin
            cycle();
            n++;
        end
        check({tag, ".reach"}, duty, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_inc[5];
        exp_inc = '{9, 10, 10, 10, 10};

        // Reset, then 30 idle cycles
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset.duty", duty, DUTY_INIT);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.ready", cmd_ready, 1);
        check("reset.period_start", period_start, 1);
        run(30);
        check("idle.duty", duty, 5);

        // Ramp 5 -> 8, rate 0, accepted at cnt 3
        wait_cnt(3);
        dut_done_cnt = 0;
        send_cmd(8, 0);
        check("up.ready_low", cmd_ready, 0);
        wait_ramp_end("up", 100, lat);
        check("up.latency", lat, (9 - 3) + 2 * PERIOD);
        check("up.final", duty, 8);
        check("up.done_now", done, 1);
        run(3);
        check("up.done_count", dut_done_cnt, 1);

        // Back to 5, then ramp 5 -> 3 at rate 2
        send_cmd(5, 0);
        wait_ramp_end("back5", 100, lat);
        wait_cnt(0);
        send_cmd(3, 2);
        wait_ramp_end("down", 200, lat);
        check("down.latency", lat, 9 + 5 * PERIOD);
        check("down.final", duty, 3);

        // Target above DUTY_MAX clamps; duty 10 keeps pwm_out high
        send_cmd(15, 0);
        wait_ramp_end("clamp", 200, lat);
        check("clamp.final", duty, DUTY_MAX);
        for (int i = 0; i < PERIOD; i++) begin
            cycle();
            check("clamp.pwm_high", pwm_out, 1);
        end

        // Same-target command: no ramp, done next cycle
        send_cmd(12, 3);
        check("same.done", done, 1);
        check("same.busy", busy, 0);

        // Manual increments from 8, saturating at DUTY_MAX
        send_cmd(8, 0);
        wait_ramp_end("to8", 100, lat);
        for (int k = 0; k < 5; k++) begin
            wait_cnt(2);
            inc_pulse = 1'b1;
            cycle();
            inc_pulse = 1'b0;
            wait_cnt(0);
            check("inc.step", duty, exp_inc[k]);
        end

        // Simultaneous inc+dec is dropped, then one dec
        wait_cnt(2);
        inc_pulse = 1'b1;
        dec_pulse = 1'b1;
        cycle();
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        wait_cnt(0);
        check("incdec.none", duty, 10);
        wait_cnt(4);
        dec_pulse = 1'b1;
        cycle();
        dec_pulse = 1'b0;
        wait_cnt(0);
        check("dec.step", duty, 9);

        // Pulse during RAMP is ignored
        send_cmd(5, 1);
        run(15);
        inc_pulse = 1'b1;
        cycle();
        inc_pulse = 1'b0;
        wait_ramp_end("ramp_pulse", 200, lat);
        run(2 * PERIOD);
        check("ramp_pulse.final", duty, 5);

        // Abort after the first step of 5 -> 9
        send_cmd(9, 0);
        wait_duty("abort1", 6, 30);
        wait_cnt(4);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort1.busy", busy, 0);
        check("abort1.done", done, 0);
        check("abort1.duty", duty, 6);
        run(2 * PERIOD);
        check("abort1.hold", duty, 6);

        // Abort coinciding with the final step: step completes, done fires
        send_cmd(5, 0);
        wait_ramp_end("to5", 50, lat);
        send_cmd(9, 0);
        wait_duty("abort2", 8, 60);
        wait_cnt(PERIOD - 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort2.duty", duty, 9);
        check("abort2.done", done, 1);
        check("abort2.busy", busy, 0);

        // Reset in the middle of a ramp
        send_cmd(2, 1);
        run(25);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_mid.duty", duty, DUTY_INIT);
        check("rst_mid.period_start", period_start, 1);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.done", done, 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cmd_valid  = ($urandom_range(19) == 0);
            cmd_target = DUTY_W'($urandom_range(15));
            cmd_rate   = RATE_W'($urandom_range(3));
            abort      = ($urandom_range(39) == 0);
            inc_pulse  = ($urandom_range(7) == 0);
            dec_pulse  = ($urandom_range(7) == 0);
            rst        = ($urandom_range(499) == 0);
            cycle();
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        rst       = 1'b0;
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Owns the PWM period counter and the duty-cycle register, and decides when and how duty changes. Sources of change: ramp commands from the control logic (valid/ready handshake) and single-step increment/decrement pulses from the button debouncers. All duty updates take effect only at a PWM period boundary, so no period is ever truncated or glitched. Sits between the debounce stage and the PWM output pin.

## Interface
- DUTY_W, 4, width of duty/target values
- PERIOD, 10, PWM period in clk cycles (counter runs 0..PERIOD-1)
- DUTY_MAX, 10, highest legal duty (100%); must be ≤ PERIOD
- DUTY_INIT, 5, duty after reset (50%)
- RATE_W, 8, width of ramp rate field

- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  ramp command present
- cmd_ready  out  1  high in IDLE only
- cmd_target  in  DUTY_W  requested final duty; values > DUTY_MAX clamp to DUTY_MAX
- cmd_rate  in  RATE_W  ramp step every (cmd_rate+1) PWM periods
- abort  in  1  stop an active ramp, hold current duty
- inc_pulse  in  1  one-cycle request: duty +1
- dec_pulse  in  1  one-cycle request: duty −1
- duty  out  DUTY_W  current applied duty
- pwm_out  out  1  (cnt < duty)
- period_start  out  1  high while cnt == 0
- busy  out  1  high in RAMP
- done  out  1  one-cycle pulse when a ramp reaches target

## Operation
- Reset: cnt=0, duty=DUTY_INIT, state IDLE, pending inc/dec cleared, step counter 0, busy=0, done=0, cmd_ready=1.
- Period counter: increments every cycle, wraps PERIOD-1 → 0. "Boundary edge" = clock edge on which cnt==PERIOD-1.
- pwm_out is combinational from registered cnt and duty. Duty 0 gives constant low. DUTY_MAX=PERIOD gives constant high.
- States: IDLE, RAMP.
- IDLE:
  - Accept a command when cmd_valid is high (cmd_ready=1). Latch tgt=min(cmd_target, DUTY_MAX) and rate.
  - If tgt==duty: stay IDLE, pulse done on the next cycle.
  - Otherwise: go to RAMP, set step counter = rate.
  - inc_pulse/dec_pulse set a single pending flag (latest wins). Both in the same cycle are ignored.
  - The pending step is applied at the next boundary edge, saturating at DUTY_MAX/0, then cleared.
  - A command accepted in the same cycle as a pulse, or while a step is pending, discards the pulse/pending step.
- RAMP:
  - On each boundary edge: if step counter==0, move duty one toward tgt and reload step counter=rate; else decrement step counter.
  - When the update makes duty==tgt: go to IDLE on that edge and assert done for exactly the following cycle.
  - inc/dec pulses are ignored. cmd_ready=0.
  - abort: go to IDLE on the next edge, duty unchanged, no done, step counter cleared. If abort coincides with the final step, the step completes and done fires.
- Width rules: duty never leaves 0..DUTY_MAX. Step counter is RATE_W bits with no wrap, since it always reloads from rate.
- rst mid-ramp overrides everything; state returns to the reset values above on the next edge.

## Timing
- Command accept to first duty change: at the first boundary edge, on which step counter==0 only if rate==0. In general the first step is (rate+1) boundary edges after accept.
- Duty change visible from cnt==0 of the following period. pwm_out reflects the new duty in that same cycle.
- Ramp length |tgt−duty0| steps → done asserted one cycle after the (|Δ|·(rate+1))-th boundary edge after accept.
- Manual step latency: applied at the first boundary edge after the pulse (≤ PERIOD cycles).
- cmd_ready reasserts in the cycle done is high.

## Test plan
- Reset, then 30 cycles idle → duty=5; pwm_out high on cnt 0–4, low on 5–9, every period; period_start every 10 cycles.
- Command target=8 rate=0 at cnt=3 → duty 6, 7, 8 at the next three period starts; busy high throughout; done one cycle after the third boundary edge; cmd_ready low during RAMP.
- Command target=3 rate=2 from duty 5 → duty 4 after 3 boundaries, 3 after 6. Command target=15 → clamps, ramps to 10; pwm_out constant high.
- Five inc_pulses spaced one per period from duty 8 → 9, 10, 10, 10, 10. Simultaneous inc+dec → no change. Pulse during RAMP → ignored.
- abort after first step of 5→9 ramp → duty stays 6, no done, IDLE next cycle. Repeat with abort on the final boundary edge → duty 9, done fires.
- rst asserted mid-ramp for one cycle → duty=5, cnt=0, busy=0, done=0 on the following cycle.
